// File: rtl/tnoc_axi_slave_read_tracker_if.sv
// Bundle of AXI read-slave channels, address-decoder hook and NoC request/response fields
// seen by the read tracker.
interface tnoc_axi_slave_read_tracker_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 64,
    parameter int AXI_ID_WIDTH  = 4,
    parameter int TAG_WIDTH     = 3
);
    // Every valid/ready pair transfers on a rising edge where both are 1; a source holds
    // its valid and payload stable until that transfer, and valid never waits on ready.
    logic                     arvalid;
    logic                     arready;
    logic [AXI_ID_WIDTH-1:0]  arid;
    logic [ADDRESS_WIDTH-1:0] araddr;
    logic [7:0]               arlen;
    logic [2:0]               arsize;
    logic [1:0]               arburst;
    logic                     rvalid;
    logic                     rready;
    logic [AXI_ID_WIDTH-1:0]  rid;
    logic [DATA_WIDTH-1:0]    rdata;
    logic [1:0]               rresp;
    logic                     rlast;
    logic [ADDRESS_WIDTH-1:0] dec_address;
    logic                     dec_invalid;
    logic                     req_valid;
    logic                     req_ready;
    logic [TAG_WIDTH-1:0]     req_tag;
    logic [ADDRESS_WIDTH-1:0] req_address;
    logic [7:0]               req_len;
    logic [2:0]               req_size;
    logic [1:0]               req_burst;
    logic                     req_invalid;
    logic                     rsp_header_valid;
    logic                     rsp_header_ready;
    logic [TAG_WIDTH-1:0]     rsp_tag;
    logic [1:0]               rsp_status;
    logic                     rsp_payload_valid;
    logic                     rsp_payload_ready;
    logic [DATA_WIDTH-1:0]    rsp_data;
    logic [1:0]               rsp_payload_status;
    logic                     rsp_last;

    modport slave (
        input  arvalid, arid, araddr, arlen, arsize, arburst, rready, dec_invalid,
               req_ready, rsp_header_valid, rsp_tag, rsp_status, rsp_payload_valid,
               rsp_data, rsp_payload_status, rsp_last,
        output arready, rvalid, rid, rdata, rresp, rlast, dec_address, req_valid,
               req_tag, req_address, req_len, req_size, req_burst, req_invalid,
               rsp_header_ready, rsp_payload_ready
    );

    modport master (
        output arvalid, arid, araddr, arlen, arsize, arburst, rready, dec_invalid,
               req_ready, rsp_header_valid, rsp_tag, rsp_status, rsp_payload_valid,
               rsp_data, rsp_payload_status, rsp_last,
        input  arready, rvalid, rid, rdata, rresp, rlast, dec_address, req_valid,
               req_tag, req_address, req_len, req_size, req_burst, req_invalid,
               rsp_header_ready, rsp_payload_ready
    );
endinterface

// File: rtl/tnoc_axi_slave_read_tracker.sv
// AXI read-slave front end: tags outstanding reads, restores RID on return, serialises
// same-ID reads and answers undecodable addresses with a local DECERR burst.
module tnoc_axi_slave_read_tracker #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 64,
    parameter int AXI_ID_WIDTH  = 4,
    parameter int TAG_WIDTH     = 3,
    parameter int LOCAL_DECERR  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    tnoc_axi_slave_read_tracker_if.slave bus,
    output logic [TAG_WIDTH:0]     outstanding,
    output logic                   tag_error,
    output logic [1:0]             fsm_state
);
    localparam int DEPTH = 1 << TAG_WIDTH;

    typedef enum logic [1:0] {IDLE = 2'd0, NET = 2'd1, LOCAL = 2'd2} r_state_e;

    r_state_e                state;
    logic [DEPTH-1:0]        busy;
    logic [AXI_ID_WIDTH-1:0] id_mem [DEPTH];
    logic [TAG_WIDTH-1:0]    free_tag;
    logic [TAG_WIDTH-1:0]    cur_tag;
    logic [1:0]              pkt_status;
    logic                    hit;
    logic                    local_pend;
    logic [AXI_ID_WIDTH-1:0] local_id;
    logic [7:0]              local_len;
    logic [7:0]              beat_cnt;
    logic                    tag_free;
    logic                    id_hit;
    logic                    local_err;
    logic                    can_accept;
    logic                    req_fire;
    logic                    local_fire;
    logic                    net_done;
    logic                    free_fire;

    // Lowest free tag wins because the scan runs downward and the last match sticks.
    always_comb begin
        tag_free = 1'b0;
        free_tag = '0;
        id_hit   = local_pend && (local_id == bus.arid);
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                tag_free = 1'b1;
                free_tag = TAG_WIDTH'(i);
            end
            if (busy[i] && (id_mem[i] == bus.arid)) id_hit = 1'b1;
        end
    end

    assign local_err  = (LOCAL_DECERR != 0) && bus.dec_invalid;
    assign can_accept = !rst && tag_free && !local_pend && !id_hit;
    assign bus.arready   = can_accept && (local_err || bus.req_ready);
    assign bus.req_valid = bus.arvalid && can_accept && !local_err;
    assign req_fire      = bus.req_valid && bus.req_ready;
    assign local_fire    = bus.arvalid && can_accept && local_err;

    assign bus.dec_address = bus.araddr;
    assign bus.req_tag     = free_tag;
    assign bus.req_address = bus.araddr;
    assign bus.req_len     = bus.arlen;
    assign bus.req_size    = bus.arsize;
    assign bus.req_burst   = bus.arburst;
    assign bus.req_invalid = (LOCAL_DECERR == 0) ? bus.dec_invalid : 1'b0;
    assign fsm_state       = state;

    always_comb begin
        bus.rvalid            = 1'b0;
        bus.rid               = '0;
        bus.rdata             = '0;
        bus.rresp             = 2'b00;
        bus.rlast             = 1'b0;
        bus.rsp_payload_ready = 1'b0;
        bus.rsp_header_ready  = !rst && (state == IDLE) && !local_pend;
        case (state)
            NET: begin
                bus.rvalid            = !rst && bus.rsp_payload_valid && hit;
                bus.rsp_payload_ready = !rst && (hit ? bus.rready : 1'b1);
                bus.rid               = id_mem[cur_tag];
                bus.rdata             = bus.rsp_data;
                bus.rlast             = bus.rsp_last;
                // An error on the beat beats an error on the packet; otherwise the beat's own status.
                if (bus.rsp_payload_status[1])  bus.rresp = bus.rsp_payload_status;
                else if (pkt_status[1])         bus.rresp = pkt_status;
                else                            bus.rresp = bus.rsp_payload_status;
            end
            LOCAL: begin
                bus.rvalid = !rst;
                bus.rid    = local_id;
                bus.rresp  = 2'b11;
                bus.rlast  = (beat_cnt == local_len);
            end
            default: ;
        endcase
    end

    assign net_done  = (state == NET) && bus.rsp_payload_valid && bus.rsp_payload_ready && bus.rsp_last;
    assign free_fire = net_done && hit;

    always_ff @(posedge clk) begin
        if (req_fire) id_mem[free_tag] <= bus.arid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= '0;
            outstanding <= '0;
            local_pend  <= 1'b0;
            local_id    <= '0;
            local_len   <= '0;
            beat_cnt    <= '0;
            cur_tag     <= '0;
            pkt_status  <= 2'b00;
            hit         <= 1'b0;
            tag_error   <= 1'b0;
        end else begin
            tag_error <= 1'b0;
            // The tag being freed was already busy, so it can never be the one allocated.
            if (free_fire) busy[cur_tag] <= 1'b0;
            if (req_fire)  busy[free_tag] <= 1'b1;
            outstanding <= outstanding + (TAG_WIDTH+1)'(req_fire) - (TAG_WIDTH+1)'(free_fire);
            if (local_fire) begin
                local_pend <= 1'b1;
                local_id   <= bus.arid;
                local_len  <= bus.arlen;
            end
            case (state)
                IDLE: begin
                    if (local_pend) begin
                        state    <= LOCAL;
                        beat_cnt <= '0;
                    end else if (bus.rsp_header_valid) begin
                        state      <= NET;
                        cur_tag    <= bus.rsp_tag;
                        pkt_status <= bus.rsp_status;
                        hit        <= busy[bus.rsp_tag];
                        tag_error  <= !busy[bus.rsp_tag];
                    end
                end
                NET: if (net_done) state <= IDLE;
                LOCAL: begin
                    if (bus.rvalid && bus.rready) begin
                        if (beat_cnt == local_len) begin
                            local_pend <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + 8'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tnoc_axi_slave_read_tracker.sv
// Directed bench for the read tracker: tag allocation, same-ID blocking, response status
// merging, local DECERR bursts, free-tag responses and reset mid-burst.
module tb_tnoc_axi_slave_read_tracker;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int IW = 4;
  localparam int TW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [TW:0]   outstanding;
  logic          tag_error;
  logic [1:0]    fsm_state;
  int            pass_cnt = 0;
  int            total_cnt = 0;
  logic [1:0]    pay_st [8];
  logic [1:0]    exp_rr [8];

  tnoc_axi_slave_read_tracker_if #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .AXI_ID_WIDTH(IW), .TAG_WIDTH(TW)
  ) bus ();

  tnoc_axi_slave_read_tracker #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .AXI_ID_WIDTH(IW), .TAG_WIDTH(TW), .LOCAL_DECERR(1)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .outstanding(outstanding),
    .tag_error(tag_error), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic ar_send(input logic [3:0] id, input logic [7:0] len, input logic inv,
                         input logic [2:0] exp_tag);
    int n = 0;
    logic [31:0] addr;
    addr = 32'h4000_0000 | (32'(id) << 8);
    @(negedge clk);
    bus.arvalid = 1'b1; bus.arid = id; bus.araddr = addr; bus.arlen = len;
    bus.arsize = 3'd3; bus.arburst = 2'b01; bus.dec_invalid = inv; bus.req_ready = 1'b1;
    #1;
    while (!bus.arready && n < 20) begin @(negedge clk); #1; n++; end
    check("ar_arready", bus.arready, 1);
    check("ar_req_valid", bus.req_valid, !inv);
    if (!inv) begin
      check("ar_req_tag", bus.req_tag, exp_tag);
      check("ar_req_address", bus.req_address, addr);
      check("ar_req_len", bus.req_len, len);
    end
    @(posedge clk); #1;
    bus.arvalid = 1'b0; bus.dec_invalid = 1'b0;
  endtask

  task automatic rsp_send(input logic [2:0] tag, input logic [1:0] pstat, input int beats,
                          input logic exp_hit, input logic [3:0] exp_rid, input int stall_beat);
    int n = 0;
    logic [63:0] data;
    @(negedge clk);
    bus.rsp_header_valid = 1'b1; bus.rsp_tag = tag; bus.rsp_status = pstat;
    #1;
    while (!bus.rsp_header_ready && n < 20) begin @(negedge clk); #1; n++; end
    check("hdr_ready", bus.rsp_header_ready, 1);
    @(posedge clk); #1;
    bus.rsp_header_valid = 1'b0;
    for (int b = 0; b < beats; b++) begin
      @(negedge clk);
      data = 64'hD000_0000_0000_0000 | (64'(tag) << 8) | 64'(b);
      bus.rsp_payload_valid = 1'b1; bus.rsp_data = data;
      bus.rsp_payload_status = pay_st[b]; bus.rsp_last = (b == beats - 1);
      bus.rready = (b != stall_beat);
      #1;
      if (b == 0) check("tag_error_pulse", tag_error, !exp_hit);
      if (b == 1) check("tag_error_clear", tag_error, 0);
      check("rvalid", bus.rvalid, exp_hit);
      if (b == stall_beat) begin
        check("stall_payload_ready", bus.rsp_payload_ready, 0);
        @(negedge clk); bus.rready = 1'b1; #1;
        check("stall_rvalid_held", bus.rvalid, 1);
      end
      check("payload_ready", bus.rsp_payload_ready, 1);
      if (exp_hit) begin
        check("rid", bus.rid, exp_rid);
        check("rdata", bus.rdata, data);
        check("rresp", bus.rresp, exp_rr[b]);
        check("rlast", bus.rlast, b == beats - 1);
      end
      @(posedge clk); #1;
    end
    bus.rsp_payload_valid = 1'b0; bus.rsp_last = 1'b0;
  endtask

  task automatic local_burst(input logic [3:0] id, input int beats);
    int n = 0;
    @(negedge clk);
    bus.rready = 1'b1;
    #1;
    while (!bus.rvalid && n < 20) begin @(negedge clk); #1; n++; end
    for (int b = 0; b < beats; b++) begin
      if (b > 0) begin @(negedge clk); #1; end
      check("local_rvalid", bus.rvalid, 1);
      check("local_rdata", bus.rdata, 0);
      check("local_rresp", bus.rresp, 2'b11);
      check("local_rid", bus.rid, id);
      check("local_rlast", bus.rlast, b == beats - 1);
      @(posedge clk);
    end
  endtask

  task automatic clear_status();
    for (int i = 0; i < 8; i++) begin pay_st[i] = 2'b00; exp_rr[i] = 2'b00; end
  endtask

  initial begin
    rst = 1'b1;
    bus.arvalid = 1'b1; bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0;
    bus.arburst = '0; bus.dec_invalid = 1'b0; bus.req_ready = 1'b1; bus.rready = 1'b1;
    bus.rsp_header_valid = 1'b0; bus.rsp_tag = '0; bus.rsp_status = '0;
    bus.rsp_payload_valid = 1'b0; bus.rsp_data = '0; bus.rsp_payload_status = '0;
    bus.rsp_last = 1'b0;
    clear_status();

    // reset state, with AR and ready inputs active to show outputs are held low
    repeat (3) @(negedge clk);
    #1;
    check("rst_arready", bus.arready, 0);
    check("rst_req_valid", bus.req_valid, 0);
    check("rst_rvalid", bus.rvalid, 0);
    check("rst_hdr_ready", bus.rsp_header_ready, 0);
    check("rst_outstanding", outstanding, 0);
    check("rst_tag_error", tag_error, 0);
    bus.arvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // eight reads IDs 0..7 fill tags 0..7
    for (int i = 0; i < 8; i++) ar_send(4'(i), 8'd1, 1'b0, 3'(i));
    @(negedge clk); #1;
    check("full_outstanding", outstanding, 8);

    // ninth read has no free tag
    bus.arvalid = 1'b1; bus.arid = 4'd8; bus.dec_invalid = 1'b0;
    #1;
    check("full_arready", bus.arready, 0);
    check("full_req_valid", bus.req_valid, 0);
    @(negedge clk); #1;
    check("full_arready_hold", bus.arready, 0);
    bus.arvalid = 1'b0;

    // free tag 0 with a stalled two-beat burst, then the ninth read takes tag 0
    rsp_send(3'd0, 2'b00, 2, 1'b1, 4'd0, 1);
    @(negedge clk); #1;
    check("free0_outstanding", outstanding, 7);
    ar_send(4'd8, 8'd1, 1'b0, 3'd0);
    @(negedge clk); #1;
    check("refill_outstanding", outstanding, 8);

    // tag 5: OKAY header, SLVERR on beat 2
    pay_st[1] = 2'b10; exp_rr[1] = 2'b10;
    rsp_send(3'd5, 2'b00, 3, 1'b1, 4'd5, -1);
    clear_status();
    @(negedge clk); #1;
    check("free5_outstanding", outstanding, 7);

    // ID 3 still busy on tag 3 blocks a new ID 3 read despite a free tag
    bus.arvalid = 1'b1; bus.arid = 4'd3; bus.arlen = 8'd3; bus.dec_invalid = 1'b0;
    #1;
    check("idhit_arready", bus.arready, 0);
    check("idhit_req_valid", bus.req_valid, 0);
    bus.arvalid = 1'b0;

    // tag 3: DECERR packet makes every beat DECERR
    for (int i = 0; i < 8; i++) exp_rr[i] = 2'b11;
    rsp_send(3'd3, 2'b11, 2, 1'b1, 4'd3, -1);
    clear_status();
    @(negedge clk); #1;
    check("free3_outstanding", outstanding, 6);
    ar_send(4'd3, 8'd3, 1'b0, 3'd3);
    @(negedge clk); #1;
    check("id3_outstanding", outstanding, 7);

    // undecodable address, three-beat local DECERR
    ar_send(4'd9, 8'd2, 1'b1, 3'd0);
    local_burst(4'd9, 3);
    @(negedge clk); #1;
    check("local_outstanding", outstanding, 7);
    check("local_idle_state", fsm_state, 2'd0);

    // response for free tag 5 is swallowed
    rsp_send(3'd5, 2'b00, 2, 1'b0, 4'd0, -1);
    @(negedge clk); #1;
    check("tagerr_outstanding", outstanding, 7);

    // reset in the middle of a burst on tag 1
    @(negedge clk);
    bus.rsp_header_valid = 1'b1; bus.rsp_tag = 3'd1; bus.rsp_status = 2'b00;
    @(posedge clk); #1;
    bus.rsp_header_valid = 1'b0;
    @(negedge clk);
    bus.rsp_payload_valid = 1'b1; bus.rsp_last = 1'b0; bus.rsp_payload_status = 2'b00;
    bus.rready = 1'b0;
    #1;
    check("midburst_rvalid", bus.rvalid, 1);
    check("midburst_rid", bus.rid, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_rvalid", bus.rvalid, 0);
    check("midrst_outstanding", outstanding, 0);
    check("midrst_state", fsm_state, 2'd0);
    rst = 1'b0;
    bus.rsp_payload_valid = 1'b0; bus.rready = 1'b1;
    @(negedge clk); #1;
    check("postrst_hdr_ready", bus.rsp_header_ready, 1);
    check("postrst_rvalid", bus.rvalid, 0);
    ar_send(4'd8, 8'd0, 1'b0, 3'd0);
    @(negedge clk); #1;
    check("postrst_outstanding", outstanding, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
